// File: rtl/reg_file.sv
// reg_file: general-purpose register file for the single-cycle ARM-style datapath.
// The file stores R0-R14 and has two combinational read ports and one clocked write port.
// Address 15 has no storage. Reads of address 15 return the externally supplied r15 (PC+8).
// Optional build macro REGFILE_BYPASS_EN adds write-through bypass on both read ports.
// With the bypass, a read of the address being written returns wd3 before the edge.
// Clocked behaviour is identical with or without the macro.
module reg_file #(
    parameter int WIDTH     = 32,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [3:0]       a1,
    input  logic [3:0]       a2,
    input  logic [3:0]       a3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [WIDTH-1:0] r15,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    localparam int                 NUM_REGS   = 15;
    localparam logic [3:0]         PC_ADDR    = 4'd15;
    localparam logic [WIDTH-1:0]   RESET_WORD = WIDTH'(RESET_VAL);

    // Current contents of R0-R14. Each register drives exactly one element of this array.
    logic [WIDTH-1:0] regs [0:NUM_REGS-1];

    // A write is effective only when it is enabled, it is not pre-empted by reset, and it targets real storage.
    logic write_ok;
    assign write_ok = we3 && !reset && (a3 != PC_ADDR);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [WIDTH-1:0] q_reg;

            // Per-register update: reset wins over any write in the same cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_reg <= RESET_WORD;
                end else if (write_ok && (a3 == 4'(gi))) begin
                    q_reg <= wd3;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    // Shared read-select logic: address 15 always yields r15 and is never bypassed.
    function automatic logic [WIDTH-1:0] read_sel(input logic [3:0] addr);
        logic [WIDTH-1:0] val;
        if (addr == PC_ADDR) begin
            val = r15;
        end else begin
            val = regs[addr];
`ifdef REGFILE_BYPASS_EN
            if (write_ok && (addr == a3)) begin
                val = wd3;
            end
`endif
        end
        return val;
    endfunction

    // Read port 1: combinational, zero latency.
    always_comb begin
        rd1 = read_sel(a1);
    end

    // Read port 2: independent of port 1; both ports may name the same register.
    always_comb begin
        rd2 = read_sel(a2);
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven directed bench for reg_file with hand-computed expectations.
// Each vector drives inputs after a falling edge and checks the reads before the next rising edge.
// It then lets that rising edge commit the vector's write and/or reset.
// The bench also checks the bypass build (REGFILE_BYPASS_EN) by applying the write-through rule to expectations.
module tb_reg_file;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         we3;
    logic [3:0]   a1, a2, a3;
    logic [W-1:0] wd3, r15;
    logic [W-1:0] rd1, rd2;

    int n_applied;
    int n_miscompares;

    reg_file #(.WIDTH(W), .RESET_VAL(0)) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .wd3   (wd3),
        .r15   (r15),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         reset;
        logic         we3;
        logic [3:0]   a1;
        logic [3:0]   a2;
        logic [3:0]   a3;
        logic [W-1:0] wd3;
        logic [W-1:0] r15;
        logic [W-1:0] exp1;
        logic [W-1:0] exp2;
        bit           check;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic we, input logic [3:0] ra1,
                                input logic [3:0] ra2, input logic [3:0] wa,
                                input logic [W-1:0] wd, input logic [W-1:0] pc,
                                input logic [W-1:0] e1, input logic [W-1:0] e2, input bit chk);
        vec_t v;
        v.reset = rst; v.we3 = we; v.a1 = ra1; v.a2 = ra2; v.a3 = wa;
        v.wd3 = wd; v.r15 = pc; v.exp1 = e1; v.exp2 = e2; v.check = chk;
        return v;
    endfunction

    // Expected value for a read port, including the write-through rule when the bypass build is selected.
    function automatic logic [W-1:0] exp_port(input logic [W-1:0] stored, input logic [3:0] addr,
                                              input logic rst, input logic we,
                                              input logic [3:0] wa, input logic [W-1:0] wd);
        logic [W-1:0] e;
        e = stored;
`ifdef REGFILE_BYPASS_EN
        if (we && !rst && wa != 4'd15 && addr != 4'd15 && addr == wa) e = wd;
`endif
        return e;
    endfunction

    task automatic check_pair(input string name, input logic [W-1:0] e1, input logic [W-1:0] e2);
        n_applied++;
        if (rd1 !== e1 || rd2 !== e2) begin
            n_miscompares++;
            if (rd1 !== e1) $display("FAIL %s rd1: got %h, expected %h", name, rd1, e1);
            if (rd2 !== e2) $display("FAIL %s rd2: got %h, expected %h", name, rd2, e2);
        end else begin
            $display("ok   %s rd1=%h rd2=%h", name, rd1, rd2);
        end
    endtask

    initial begin
        n_applied     = 0;
        n_miscompares = 0;
        reset = 1'b0; we3 = 1'b0; a1 = 4'd0; a2 = 4'd0; a3 = 4'd0; wd3 = '0; r15 = '0;

        // Expectations are the stored contents before each vector's rising edge.
        vecs[0]  = mk(1, 1, 4'd1,  4'd14, 4'd1,  32'd55,        32'd1515, 32'd0,         32'd0,         0);
        vecs[1]  = mk(0, 0, 4'd0,  4'd14, 4'd0,  32'd0,         32'd1515, 32'd0,         32'd0,         1);
        vecs[2]  = mk(0, 1, 4'd0,  4'd15, 4'd0,  32'd0,         32'd1515, 32'd0,         32'd1515,      1);
        vecs[3]  = mk(0, 1, 4'd1,  4'd15, 4'd1,  32'd1,         32'd1515, 32'd0,         32'd1515,      1);
        vecs[4]  = mk(0, 1, 4'd1,  4'd2,  4'd2,  32'd2,         32'd1515, 32'd1,         32'd0,         1);
        vecs[5]  = mk(0, 1, 4'd3,  4'd2,  4'd3,  32'd3,         32'd1515, 32'd0,         32'd2,         1);
        vecs[6]  = mk(0, 0, 4'd1,  4'd15, 4'd3,  32'd3,         32'd1515, 32'd1,         32'd1515,      1);
        vecs[7]  = mk(0, 0, 4'd3,  4'd15, 4'd3,  32'd3,         32'd1515, 32'd3,         32'd1515,      1);
        vecs[8]  = mk(0, 0, 4'd0,  4'd1,  4'd0,  32'd0,         32'd1515, 32'd0,         32'd1,         1);
        vecs[9]  = mk(0, 0, 4'd2,  4'd3,  4'd0,  32'd0,         32'd1515, 32'd2,         32'd3,         1);
        vecs[10] = mk(0, 0, 4'd2,  4'd3,  4'd0,  32'd0,         32'd1515, 32'd2,         32'd3,         1);
        vecs[11] = mk(0, 1, 4'd15, 4'd14, 4'd15, 32'hDEADBEEF,  32'd1515, 32'd1515,      32'd0,         1);
        vecs[12] = mk(0, 0, 4'd15, 4'd15, 4'd15, 32'hDEADBEEF,  32'd2000, 32'd2000,      32'd2000,      1);
        vecs[13] = mk(0, 0, 4'd0,  4'd1,  4'd15, 32'd0,         32'd2000, 32'd0,         32'd1,         1);
        vecs[14] = mk(0, 0, 4'd2,  4'd2,  4'd2,  32'd99,        32'd2000, 32'd2,         32'd2,         1);
        vecs[15] = mk(0, 0, 4'd2,  4'd2,  4'd2,  32'd99,        32'd2000, 32'd2,         32'd2,         1);
        vecs[16] = mk(0, 0, 4'd2,  4'd14, 4'd2,  32'd99,        32'd2000, 32'd2,         32'd0,         1);
        vecs[17] = mk(0, 1, 4'd14, 4'd3,  4'd14, 32'hA5A5A5A5,  32'd2000, 32'd0,         32'd3,         1);
        vecs[18] = mk(0, 0, 4'd14, 4'd13, 4'd14, 32'd0,         32'd2000, 32'hA5A5A5A5,  32'd0,         1);
        vecs[19] = mk(1, 1, 4'd1,  4'd14, 4'd1,  32'd55,        32'd2000, 32'd1,         32'hA5A5A5A5,  1);
        vecs[20] = mk(0, 0, 4'd1,  4'd14, 4'd1,  32'd55,        32'd2000, 32'd0,         32'd0,         1);
        vecs[21] = mk(0, 0, 4'd2,  4'd3,  4'd1,  32'd55,        32'd2000, 32'd0,         32'd0,         1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = vecs[i].reset; we3 = vecs[i].we3;
            a1 = vecs[i].a1; a2 = vecs[i].a2; a3 = vecs[i].a3;
            wd3 = vecs[i].wd3; r15 = vecs[i].r15;
            #1;
            if (vecs[i].check)
                check_pair($sformatf("vec%0d", i),
                           exp_port(vecs[i].exp1, vecs[i].a1, vecs[i].reset, vecs[i].we3, vecs[i].a3, vecs[i].wd3),
                           exp_port(vecs[i].exp2, vecs[i].a2, vecs[i].reset, vecs[i].we3, vecs[i].a3, vecs[i].wd3));
        end

        // r15 follows combinationally with no clock edge in between.
        @(negedge clk);
        we3 = 1'b0; a1 = 4'd15; a2 = 4'd15; r15 = 32'd1515;
        #1;
        check_pair("r15_comb_a", 32'd1515, 32'd1515);
        r15 = 32'd2000;
        #1;
        check_pair("r15_comb_b", 32'd2000, 32'd2000);

        // Same-cycle write to R4 (currently RESET_VAL). It is visible before the edge only in the bypass build.
        we3 = 1'b1; a3 = 4'd4; wd3 = 32'd7; a1 = 4'd4; a2 = 4'd15;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_pair("bypass_r4", 32'd7, 32'd2000);
`else
        check_pair("no_bypass_r4", 32'd0, 32'd2000);
`endif
        @(negedge clk);
        we3 = 1'b0;
        #1;
        check_pair("after_write_r4", 32'd7, 32'd2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose register file for the single-cycle ARM-style CPU datapath.
- Holds architectural registers R0–R14 as storage, with two combinational read ports and one clocked write port.
- Address 15 is not stored: reads of R15 return the externally supplied r15 value (PC+8 from the datapath).

Parameters:
- WIDTH, 32, data width of every register, write data, r15 input and read outputs.
- RESET_VAL, 0, value loaded into R0–R14 on reset, truncated/extended to WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- we3  input  1  write enable for write port 3.
- a1  input  4  read address, port 1.
- a2  input  4  read address, port 2.
- a3  input  4  write address, port 3.
- wd3  input  WIDTH  write data, port 3.
- r15  input  WIDTH  value returned for reads of register 15 (PC+8).
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: 15 registers, R0–R14, each WIDTH bits. There is no storage for index 15.
- Reset:
  - On a rising edge with reset=1, all of R0–R14 load RESET_VAL.
  - Reset has priority over a write in the same cycle; that write is discarded.
  - Reset is honoured mid-operation with no additional latency.
- Write:
  - On a rising edge with reset=0 and we3=1 and a3 != 15, R[a3] <= wd3.
  - When a3 == 15 the write is ignored and no state changes.
  - When we3=0 no state changes.
- Read:
  - Purely combinational, zero latency.
  - rdN = r15 when aN == 15; otherwise rdN = R[aN].
  - Both ports are independent; a1 == a2 is legal and both ports return the same value.
  - rd outputs follow r15 combinationally whenever the address is 15.
- Read during write (feature disabled): a read of the address being written returns the old value until the rising edge, then the new value.
- After reset, every read of 0–14 returns RESET_VAL until that register is written.
- Undefined inputs: no X-propagation handling is required beyond plain RTL semantics.
- Only a3 selects a write target; there is no other side channel.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined:
  - Write-through bypass on both read ports.
  - If we3=1, reset=0, a3 != 15 and aN == a3, then rdN = wd3 in the same cycle, before the edge.
  - Address 15 is never bypassed; it always returns r15.
- When undefined: reads return the stored value only, as specified in Behaviour.
- Clocked state is identical in both builds.

Test Plan:
- Reset then read:
  - Stimulus: reset=1 for one edge, then a1=0, a2=14.
  - Required: rd1=0 and rd2=0 (RESET_VAL).
- Sequential write/readback:
  - Stimulus: we3=1 write R0=0, R1=1, R2=2, R3=3 on consecutive edges; r15=1515; then we3=0.
  - a1=1, a2=15 -> rd1=1, rd2=1515.
  - a1=3, a2=15 -> rd1=3, rd2=1515.
- Dual read, no write:
  - Stimulus: we3=0 after the writes above.
  - a1=0, a2=1 -> rd1=0, rd2=1.
  - a1=2, a2=3 -> rd1=2, rd2=3.
  - Values stay stable over multiple cycles.
- R15 handling:
  - Stimulus: we3=1, a3=15, wd3=0xDEADBEEF, r15=1515; then set r15=2000 with a1=15.
  - Required: rd1=1515, then rd1=2000 combinationally.
  - R0–R14 are unchanged by the a3=15 write.
- Write disabled:
  - Stimulus: we3=0, a3=2, wd3=99 for several edges.
  - Required: a1=2 -> rd1=2.
- Reset mid-operation:
  - Stimulus: reset=1 and we3=1, a3=1, wd3=55 on the same edge.
  - Required: a1=1 -> rd1=0.
  - With REGFILE_BYPASS_EN, before the edge with reset=0: we3=1, a3=4, wd3=7, a1=4 -> rd1=7 immediately.
